vtg_deserializer: RTL and testbench
===================================

// Module: vtg_deserializer
//
// PURPOSE
//  Serial-to-parallel front stage. Assembles a SIZE-bit word from a 1-bit serial
//  stream with framing and optional even parity. Drives datain/we of a downstream
//  vtg_register: word_out goes to datain, word_we goes to we.
//  Only complete, parity-checked words reach the register.
//
// PARAMETERS
//  SIZE       4  word width in bits (>=1)
//  MSB_FIRST  1  1: first serial bit lands in word_out[SIZE-1]; 0: lands in word_out[0]
//  PARITY_EN  0  1: one even-parity bit follows the SIZE data bits
//
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  sin_valid  in   1     sin_bit/sin_start are sampled only when high
//  sin_start  in   1     qualified by sin_valid; marks first data bit of a frame
//  sin_bit    in   1     serial data/parity bit
//  word_out   out  SIZE  last good assembled word; held between frames
//  word_we    out  1     1-cycle pulse: word_out updated with new word
//  busy       out  1     frame in progress (state != IDLE)
//  par_err    out  1     1-cycle pulse: parity mismatch, word dropped
//  frame_err  out  1     1-cycle pulse: sin_start arrived mid-frame, partial word dropped
//
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-frame): word_out=0, word_we=0, busy=0, par_err=0,
//    frame_err=0, state=IDLE, bit count=0. Partial frame discarded; no word_we pulse.
//  - FSM states: IDLE, SHIFT, PARITY.
//  - IDLE: sin_valid && !sin_start -> bit ignored. sin_valid && sin_start -> bit is data
//    bit 0 of the frame, count=1, go SHIFT.
//    SIZE==1: frame completes on this edge (PARITY_EN=0) or goes PARITY.
//  - SHIFT: each sin_valid cycle shifts in one bit, count++.
//    sin_valid low: hold state/count, no timeout.
//    When count reaches SIZE: go PARITY (PARITY_EN=1) or complete.
//  - PARITY: next valid bit p is checked.
//    ^data ^ p == 0 -> complete.
//    Else par_err=1 for one cycle, word_out unchanged, go IDLE.
//  - Complete: on the edge that samples the final data/parity bit:
//    - word_out takes the new word;
//    - word_we=1 for the following cycle only;
//    - state -> IDLE on the same edge.
//    Latency: word valid 1 cycle after final bit sampled.
//  - sin_start with sin_valid in SHIFT or PARITY: frame_err=1 for one cycle, partial
//    word dropped, that bit starts a new frame (count=1, SHIFT). No bit lost.
//  - Back-to-back frames, zero idle cycles: supported. A start bit arriving in the
//    cycle word_we is high is accepted normally.
//  - busy=1 from the edge accepting a start bit until the edge completing or
//    aborting the frame.
//  - Bit counter width $clog2(SIZE+1); saturates never (SIZE bound ends frame).
//  - word_we, par_err, frame_err are mutually exclusive in any cycle.
//
// STRUCTURE
//  - vtg_pkg: state encodings (ST_IDLE, ST_SHIFT, ST_PARITY as 2-bit localparams)
//    and a shared counter-width function clog2.
//  - Shift register, counter and FSM are local.
//  - Holding register reuses vtg_register #(.SIZE(SIZE), .RST_VAL({SIZE{1'b0}})):
//    - datain = next shift value;
//    - we = combinational completion condition, so word_out updates on the completing edge.
//  - word_we is a registered copy of that completion condition.
//
// TESTING
//  1. SIZE=4, MSB_FIRST=1: start+bits 1,0,1,1 on 4 consecutive cycles
//     -> word_we pulse the cycle after bit 4, word_out=4'b1011, busy low after.
//  2. MSB_FIRST=0, same stream -> word_out=4'b1101.
//  3. sin_valid low 3 cycles between bits 2 and 3 -> busy held 1, result still 4'b1011,
//     exactly one word_we pulse.
//  4. PARITY_EN=1: 0101 + p=0 -> word_out=4'b0101 with word_we.
//     Then 0111 + p=0 -> par_err pulse, no word_we, word_out stays 4'b0101.
//  5. Start, 2 bits, then sin_start with 1,1,1,1 -> frame_err pulse on restart,
//     then word_out=4'b1111 with word_we.
//  6. rst high after 2 bits -> all outputs 0 next cycle, no word_we.
//     Then frames 1010,0101 back-to-back -> word_we pulses 4 cycles apart, values in order.

Source files
------------

// File: rtl/vtg_pkg.sv
// Shared definitions for the vtg serial front end: FSM state encodings and a
// constant-foldable ceil(log2) used to size bit counters.
package vtg_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    // Smallest number of bits able to index 'value' distinct codes.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'sd1 <<< i) < 64'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vtg_register.sv
// Holding register with write enable and synchronous reset to a fixed value.
module vtg_register #(
    parameter int              SIZE    = 4,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [SIZE-1:0] datain,
    output logic [SIZE-1:0] dataout
);

    logic [SIZE-1:0] data_d;
    logic [SIZE-1:0] data_q;

    // Load new data only when write enable is asserted.
    always_comb begin
        if (we) begin
            data_d = datain;
        end else begin
            data_d = data_q;
        end
    end

    // Storage flop with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dataout = data_q;

endmodule

// File: rtl/vtg_deserializer.sv
// Serial-to-parallel front stage: frames a SIZE-bit word from a qualified
// 1-bit stream, optionally checks even parity, and writes only good words
// into the holding register.
module vtg_deserializer
    import vtg_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sin_valid,
    input  logic            sin_start,
    input  logic            sin_bit,
    output logic [SIZE-1:0] word_out,
    output logic            word_we,
    output logic            busy,
    output logic            par_err,
    output logic            frame_err
);

    localparam int            CW         = clog2(SIZE + 1);
    localparam bit            START_DONE = (SIZE == 1) && (PARITY_EN == 0);
    localparam logic [1:0]    START_ST   = (SIZE == 1) ? ((PARITY_EN != 0) ? ST_PARITY : ST_IDLE)
                                                       : ST_SHIFT;
    localparam logic [CW-1:0] START_CNT  = START_DONE ? {CW{1'b0}} : CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SIZE - 1);

    logic [1:0]      state_d,     state_q;
    logic [CW-1:0]   cnt_d,       cnt_q;
    logic [SIZE-1:0] shift_d,     shift_q;
    logic            word_we_d,   word_we_q;
    logic            par_err_d,   par_err_q;
    logic            frame_err_d, frame_err_q;
    logic [SIZE-1:0] shift_nxt;
    logic            start_s;
    logic            complete_s;

    assign start_s = sin_valid & sin_start;

    // Shift register input: the first bit of a frame ends up at the MSB or LSB.
    if (SIZE == 1) begin : g_one
        assign shift_nxt = sin_bit;
    end else if (MSB_FIRST != 0) begin : g_msb
        assign shift_nxt = {shift_q[SIZE-2:0], sin_bit};
    end else begin : g_lsb
        assign shift_nxt = {sin_bit, shift_q[SIZE-1:1]};
    end

    // State, counter, shift register and pulse flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            shift_q     <= {SIZE{1'b0}};
            word_we_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            word_we_q   <= word_we_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next state: a start bit always (re)opens a frame; otherwise advance per state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE, ST_SHIFT, ST_PARITY: begin
                if (start_s) begin
                    state_d = START_ST;
                    cnt_d   = START_CNT;
                    shift_d = shift_nxt;
                end else if (sin_valid && (state_q == ST_SHIFT)) begin
                    shift_d = shift_nxt;
                    if (cnt_q == CNT_LAST) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_IDLE;
                        cnt_d   = (PARITY_EN != 0) ? (cnt_q + CW'(1)) : {CW{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else if (sin_valid && (state_q == ST_PARITY)) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Outputs: completion strobe into the holding register and error pulses.
    always_comb begin
        complete_s  = 1'b0;
        par_err_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s && START_DONE) begin
                    complete_s = 1'b1;
                end else begin
                    complete_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (start_s) begin
                    frame_err_d = 1'b1;
                end else if (sin_valid && (cnt_q == CNT_LAST) && (PARITY_EN == 0)) begin
                    complete_s = 1'b1;
                end else begin
                    complete_s = 1'b0;
                end
            end
            ST_PARITY: begin
                if (start_s) begin
                    frame_err_d = 1'b1;
                end else if (sin_valid) begin
                    if (((^shift_q) ^ sin_bit) == 1'b0) begin
                        complete_s = 1'b1;
                    end else begin
                        par_err_d  = 1'b1;
                    end
                end else begin
                    complete_s = 1'b0;
                end
            end
            default: begin
                complete_s = 1'b0;
            end
        endcase
        word_we_d = complete_s;
    end

    // The register loads on the completing edge, so word_out and word_we align.
    vtg_register #(
        .SIZE    (SIZE),
        .RST_VAL ({SIZE{1'b0}})
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .we      (complete_s),
        .datain  (shift_d),
        .dataout (word_out)
    );

    assign word_we   = word_we_q;
    assign par_err   = par_err_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vtg_deserializer.sv
// Directed bench for vtg_deserializer: three instances (MSB-first, LSB-first,
// MSB-first with parity) share one stimulus bus gated by 'sel'; expected words
// go through a scoreboard queue and are popped when word_we is observed.
module tb_vtg_deserializer;

    typedef struct packed {
        logic [1:0] inst;
        logic [3:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin_valid, sin_start, sin_bit;
    int         sel;
    logic [3:0] wo     [3];
    logic       we_o   [3];
    logic       busy_o [3];
    logic       pe_o   [3];
    logic       fe_o   [3];

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   we_cnt [3]  = '{default: 0};
    int   pe_cnt [3]  = '{default: 0};
    int   fe_cnt [3]  = '{default: 0};

    always #5 clk = ~clk;

    vtg_deserializer #(.SIZE(4), .MSB_FIRST(1), .PARITY_EN(0)) u0 (
        .clk(clk), .rst(rst), .sin_valid(sin_valid && (sel == 0)), .sin_start(sin_start),
        .sin_bit(sin_bit), .word_out(wo[0]), .word_we(we_o[0]), .busy(busy_o[0]),
        .par_err(pe_o[0]), .frame_err(fe_o[0]));

    vtg_deserializer #(.SIZE(4), .MSB_FIRST(0), .PARITY_EN(0)) u1 (
        .clk(clk), .rst(rst), .sin_valid(sin_valid && (sel == 1)), .sin_start(sin_start),
        .sin_bit(sin_bit), .word_out(wo[1]), .word_we(we_o[1]), .busy(busy_o[1]),
        .par_err(pe_o[1]), .frame_err(fe_o[1]));

    vtg_deserializer #(.SIZE(4), .MSB_FIRST(1), .PARITY_EN(1)) u2 (
        .clk(clk), .rst(rst), .sin_valid(sin_valid && (sel == 2)), .sin_start(sin_start),
        .sin_bit(sin_bit), .word_out(wo[2]), .word_we(we_o[2]), .busy(busy_o[2]),
        .par_err(pe_o[2]), .frame_err(fe_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Look at every instance's pulses once per cycle; pop the scoreboard on word_we.
    task automatic scan();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (we_o[k] === 1'b1) begin
                we_cnt[k]++;
                chk("sb_expected_word", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_word", 32'({k[1:0], wo[k]}), 32'({e.inst, e.word}));
                end
            end
            if (pe_o[k] === 1'b1) pe_cnt[k]++;
            if (fe_o[k] === 1'b1) fe_cnt[k]++;
            if ((we_o[k] | pe_o[k] | fe_o[k]) === 1'b1) begin
                chk("pulse_exclusive", 32'(we_o[k]) + 32'(pe_o[k]) + 32'(fe_o[k]), 32'd1);
            end
        end
    endtask

    // Drive one cycle of inputs, then observe the outputs produced by that edge.
    task automatic step(input logic v, input logic s, input logic b);
        sin_valid = v;
        sin_start = s;
        sin_bit   = b;
        @(negedge clk);
        #1;
        scan();
    endtask

    task automatic send4(input logic [3:0] bits);
        step(1'b1, 1'b1, bits[3]);
        step(1'b1, 1'b0, bits[2]);
        step(1'b1, 1'b0, bits[1]);
        step(1'b1, 1'b0, bits[0]);
    endtask

    task automatic push(input int inst, input logic [3:0] word);
        exp_t e;
        e.inst = inst[1:0];
        e.word = word;
        sb_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; sel = 0;
        sin_valid = 1'b0; sin_start = 1'b0; sin_bit = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_word_out", 32'(wo[k]), 32'd0);
            chk("rst_word_we", 32'(we_o[k]), 32'd0);
            chk("rst_busy", 32'(busy_o[k]), 32'd0);
            chk("rst_par_err", 32'(pe_o[k]), 32'd0);
            chk("rst_frame_err", 32'(fe_o[k]), 32'd0);
        end

        // 1: MSB first, 1,0,1,1 -> 1011 one cycle after the last bit
        sel = 0;
        step(1'b1, 1'b1, 1'b1);
        chk("t1_busy_start", 32'(busy_o[0]), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        push(0, 4'b1011);
        step(1'b1, 1'b0, 1'b1);
        chk("t1_we", 32'(we_o[0]), 32'd1);
        chk("t1_word", 32'(wo[0]), 32'hB);
        chk("t1_busy_done", 32'(busy_o[0]), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_we_one_cycle", 32'(we_o[0]), 32'd0);
        chk("t1_word_held", 32'(wo[0]), 32'hB);

        // 2: LSB first, same stream -> 1101
        sel = 1;
        push(1, 4'b1101);
        send4(4'b1011);
        chk("t2_we", 32'(we_o[1]), 32'd1);
        chk("t2_word", 32'(wo[1]), 32'hD);
        step(1'b0, 1'b0, 1'b0);

        // 3: valid gap of 3 cycles between bits 2 and 3
        sel = 0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("t3_busy_gap", 32'(busy_o[0]), 32'd1);
            chk("t3_we_gap", 32'(we_o[0]), 32'd0);
        end
        step(1'b1, 1'b0, 1'b1);
        push(0, 4'b1011);
        step(1'b1, 1'b0, 1'b1);
        chk("t3_we", 32'(we_o[0]), 32'd1);
        chk("t3_word", 32'(wo[0]), 32'hB);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_we_count", 32'(we_cnt[0]), 32'd2);

        // 4: parity enabled, good then bad parity
        sel = 2;
        send4(4'b0101);
        chk("t4_busy_parity", 32'(busy_o[2]), 32'd1);
        chk("t4_no_we_before_parity", 32'(we_o[2]), 32'd0);
        push(2, 4'b0101);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_we_good", 32'(we_o[2]), 32'd1);
        chk("t4_word_good", 32'(wo[2]), 32'h5);
        send4(4'b0111);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_par_err", 32'(pe_o[2]), 32'd1);
        chk("t4_no_we_bad", 32'(we_o[2]), 32'd0);
        chk("t4_word_kept", 32'(wo[2]), 32'h5);
        chk("t4_busy_after_err", 32'(busy_o[2]), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_par_err_one_cycle", 32'(pe_o[2]), 32'd0);
        chk("t4_we_count", 32'(we_cnt[2]), 32'd1);

        // 5: restart mid-frame
        sel = 0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t5_frame_err", 32'(fe_o[0]), 32'd1);
        chk("t5_busy_restart", 32'(busy_o[0]), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("t5_frame_err_one_cycle", 32'(fe_o[0]), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        push(0, 4'b1111);
        step(1'b1, 1'b0, 1'b1);
        chk("t5_we", 32'(we_o[0]), 32'd1);
        chk("t5_word", 32'(wo[0]), 32'hF);
        step(1'b0, 1'b0, 1'b0);

        // 6: reset mid-frame, then back-to-back frames
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t6_rst_word", 32'(wo[0]), 32'd0);
        chk("t6_rst_we", 32'(we_o[0]), 32'd0);
        chk("t6_rst_busy", 32'(busy_o[0]), 32'd0);
        chk("t6_rst_par_err", 32'(pe_o[0]), 32'd0);
        chk("t6_rst_frame_err", 32'(fe_o[0]), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_no_we_after_rst", 32'(we_o[0]), 32'd0);
        push(0, 4'b1010);
        send4(4'b1010);
        chk("t6_we_first", 32'(we_o[0]), 32'd1);
        chk("t6_word_first", 32'(wo[0]), 32'hA);
        push(0, 4'b0101);
        step(1'b1, 1'b1, 1'b0);
        chk("t6_we_gap1", 32'(we_o[0]), 32'd0);
        chk("t6_busy_b2b", 32'(busy_o[0]), 32'd1);
        chk("t6_frame_err_b2b", 32'(fe_o[0]), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("t6_we_gap2", 32'(we_o[0]), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_we_gap3", 32'(we_o[0]), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("t6_we_second", 32'(we_o[0]), 32'd1);
        chk("t6_word_second", 32'(wo[0]), 32'h5);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("we_count_u0", 32'(we_cnt[0]), 32'd5);
        chk("we_count_u1", 32'(we_cnt[1]), 32'd1);
        chk("we_count_u2", 32'(we_cnt[2]), 32'd1);
        chk("frame_err_count_u0", 32'(fe_cnt[0]), 32'd1);
        chk("par_err_count_u2", 32'(pe_cnt[2]), 32'd1);
        chk("par_err_count_u0", 32'(pe_cnt[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
